// File: rtl/dtcore32_csr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dtcore32_csr_pkg
// Purpose  : Shared CSR definitions for the dtcore32 machine-mode CSR file.
//            CSR addresses, mstatus field positions, trap cause codes, the
//            writeback bundle struct and write-legalisation helpers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package dtcore32_csr_pkg;

  // Machine-mode CSR addresses
  localparam logic [11:0] CSR_MSTATUS    = 12'h300;
  localparam logic [11:0] CSR_MISA       = 12'h301;
  localparam logic [11:0] CSR_MIE        = 12'h304;
  localparam logic [11:0] CSR_MTVEC      = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH   = 12'h340;
  localparam logic [11:0] CSR_MEPC       = 12'h341;
  localparam logic [11:0] CSR_MCAUSE     = 12'h342;
  localparam logic [11:0] CSR_MTVAL      = 12'h343;
  localparam logic [11:0] CSR_MIP        = 12'h344;
  localparam logic [11:0] CSR_MCYCLE     = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET   = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH    = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH  = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID  = 12'hF11;
  localparam logic [11:0] CSR_MARCHID    = 12'hF12;
  localparam logic [11:0] CSR_MIMPID     = 12'hF13;
  localparam logic [11:0] CSR_MHARTID    = 12'hF14;
  localparam logic [11:0] CSR_MCONFIGPTR = 12'hF15;

  // mstatus layout
  localparam int          MSTATUS_MIE_BIT  = 3;
  localparam int          MSTATUS_MPIE_BIT = 7;
  localparam logic [1:0]  MSTATUS_MPP_M    = 2'b11;
  localparam logic [31:0] MSTATUS_WMASK    = 32'h0000_0088;
  localparam logic [31:0] MSTATUS_MPP_BITS = {19'd0, MSTATUS_MPP_M, 11'd0};

  // Synchronous exception cause codes
  localparam logic [31:0] TRAP_INSN_MISALIGNED = 32'd0;
  localparam logic [31:0] TRAP_INSN_FAULT      = 32'd1;
  localparam logic [31:0] TRAP_ILLEGAL_INSN    = 32'd2;
  localparam logic [31:0] TRAP_BREAKPOINT      = 32'd3;
  localparam logic [31:0] TRAP_LOAD_MISALIGNED = 32'd4;
  localparam logic [31:0] TRAP_STORE_MISALIGN  = 32'd6;
  localparam logic [31:0] TRAP_ECALL_M         = 32'd11;

  // Everything the writeback stage hands to the CSR file in one cycle
  typedef struct packed {
    logic        valid;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        trap_valid;
    logic [31:0] trap_mcause;
    logic [31:0] trap_pc;
    logic [31:0] trap_mtval;
    logic        mret;
  } csr_wb_t;

  // CSRs that hold software-writable state. Writes elsewhere are dropped.
  function automatic logic csr_is_writable(input logic [11:0] addr);
    case (addr)
      CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
      CSR_MTVAL, CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH:
        csr_is_writable = 1'b1;
      default:
        csr_is_writable = 1'b0;
    endcase
  endfunction

  // Value a write would leave in the CSR, as seen on a subsequent read
  function automatic logic [31:0] csr_legalize(input logic [11:0] addr,
                                               input logic [31:0] wdata);
    case (addr)
      CSR_MSTATUS:          csr_legalize = (wdata & MSTATUS_WMASK) | MSTATUS_MPP_BITS;
      CSR_MTVEC, CSR_MEPC:  csr_legalize = {wdata[31:2], 2'b00};
      default:              csr_legalize = wdata;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dtcore32_csr_counter64.sv
`default_nettype none
// ============================================================================
// Module   : dtcore32_csr_counter64
// Purpose  : 64-bit performance counter with independently writable halves.
//            A write to either half suppresses that cycle's increment; the
//            carry into the upper half happens in the same cycle.
// Ports    : clk, rst_n      - clock, async active-low reset
//            inc_i           - count this cycle
//            wr_lo_i/wr_hi_i - replace bits [31:0] / [63:32] with wdata_i
//            count_o         - current 64-bit count
// Revision : 1.0 - initial release
// ============================================================================
module dtcore32_csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] count_o
);

  logic [63:0] count_q;
  logic [63:0] count_d;

  always_comb begin
    count_d = count_q;
    if (wr_lo_i || wr_hi_i) begin
      if (wr_lo_i) count_d[31:0]  = wdata_i;
      if (wr_hi_i) count_d[63:32] = wdata_i;
    end else if (inc_i) begin
      count_d = count_q + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= 64'd0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/dtcore32_csr_file.sv
`default_nettype none
// ============================================================================
// Module   : dtcore32_csr_file
// Purpose  : Machine-mode CSR file. Combinational read port for decode,
//            write/trap/MRET commit from writeback, mcycle/minstret counters,
//            trap vector and return PC for fetch.
// Ports    : id_csr_*_i/o  - decode read port and legality flag
//            wb_*_i        - writeback commit (CSR write, trap, MRET)
//            trap_vector_o - {mtvec[31:2], 2'b00}
//            mepc_o        - current mepc
// Revision : 1.0 - initial release
// ============================================================================
module dtcore32_csr_file
  import dtcore32_csr_pkg::*;
#(
  parameter logic [31:0] MHARTID    = 32'd0,
  parameter logic [31:0] MISA_VALUE = 32'h4000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] id_csr_addr_i,
  input  logic        id_csr_we_i,
  output logic [31:0] id_csr_rdata_o,
  output logic        id_csr_illegal_o,
  input  logic        wb_valid_i,
  input  logic        wb_csr_we_i,
  input  logic [11:0] wb_csr_addr_i,
  input  logic [31:0] wb_csr_wdata_i,
  input  logic        wb_trap_valid_i,
  input  logic [31:0] wb_trap_mcause_i,
  input  logic [31:0] wb_trap_pc_i,
  input  logic [31:0] wb_trap_mtval_i,
  input  logic        wb_mret_i,
  output logic [31:0] trap_vector_o,
  output logic [31:0] mepc_o
);

  csr_wb_t wb;
  assign wb = '{valid:       wb_valid_i,
                csr_we:      wb_csr_we_i,
                csr_addr:    wb_csr_addr_i,
                csr_wdata:   wb_csr_wdata_i,
                trap_valid:  wb_trap_valid_i,
                trap_mcause: wb_trap_mcause_i,
                trap_pc:     wb_trap_pc_i,
                trap_mtval:  wb_trap_mtval_i,
                mret:        wb_mret_i};

  logic w_trap, w_mret, w_wr;
  assign w_trap = wb.valid && wb.trap_valid;
  assign w_mret = wb.valid && wb.mret && !wb.trap_valid;
  assign w_wr   = wb.valid && wb.csr_we && !wb.trap_valid;

  logic [31:0] w_wval;
  assign w_wval = csr_legalize(wb.csr_addr, wb.csr_wdata);

  // State registers; mstatus keeps only its two writable bits
  logic        st_mie_q, st_mie_d;
  logic        st_mpie_q, st_mpie_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;

  always_comb begin
    st_mie_d   = st_mie_q;
    st_mpie_d  = st_mpie_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    if (w_trap) begin
      // Trap entry overrides any write or MRET on the same instruction
      mepc_d    = {wb.trap_pc[31:2], 2'b00};
      mcause_d  = wb.trap_mcause;
      mtval_d   = wb.trap_mtval;
      st_mpie_d = st_mie_q;
      st_mie_d  = 1'b0;
    end else begin
      if (w_wr) begin
        case (wb.csr_addr)
          CSR_MSTATUS: begin
            st_mie_d  = w_wval[MSTATUS_MIE_BIT];
            st_mpie_d = w_wval[MSTATUS_MPIE_BIT];
          end
          CSR_MIE:      mie_d      = w_wval;
          CSR_MTVEC:    mtvec_d    = w_wval;
          CSR_MSCRATCH: mscratch_d = w_wval;
          CSR_MEPC:     mepc_d     = w_wval;
          CSR_MCAUSE:   mcause_d   = w_wval;
          CSR_MTVAL:    mtval_d    = w_wval;
          default: ;
        endcase
      end
      // Placed after the write so MRET wins on mstatus
      if (w_mret) begin
        st_mie_d  = st_mpie_q;
        st_mpie_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_mie_q   <= 1'b0;
      st_mpie_q  <= 1'b0;
      mie_q      <= 32'd0;
      mtvec_q    <= 32'd0;
      mscratch_q <= 32'd0;
      mepc_q     <= 32'd0;
      mcause_q   <= 32'd0;
      mtval_q    <= 32'd0;
    end else begin
      st_mie_q   <= st_mie_d;
      st_mpie_q  <= st_mpie_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
    end
  end

  // Counters
  logic [63:0] mcycle, minstret;

  dtcore32_csr_counter64 u_mcycle (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (1'b1),
    .wr_lo_i (w_wr && (wb.csr_addr == CSR_MCYCLE)),
    .wr_hi_i (w_wr && (wb.csr_addr == CSR_MCYCLEH)),
    .wdata_i (wb.csr_wdata),
    .count_o (mcycle)
  );

  dtcore32_csr_counter64 u_minstret (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (wb.valid && !wb.trap_valid),
    .wr_lo_i (w_wr && (wb.csr_addr == CSR_MINSTRET)),
    .wr_hi_i (w_wr && (wb.csr_addr == CSR_MINSTRETH)),
    .wdata_i (wb.csr_wdata),
    .count_o (minstret)
  );

  // Read port
  logic [31:0] rd_data;
  logic        rd_impl;

  always_comb begin
    rd_data = 32'd0;
    rd_impl = 1'b1;
    case (id_csr_addr_i)
      CSR_MSTATUS:    rd_data = MSTATUS_MPP_BITS
                              | ({31'd0, st_mie_q}  << MSTATUS_MIE_BIT)
                              | ({31'd0, st_mpie_q} << MSTATUS_MPIE_BIT);
      CSR_MISA:       rd_data = MISA_VALUE;
      CSR_MIE:        rd_data = mie_q;
      CSR_MTVEC:      rd_data = mtvec_q;
      CSR_MSCRATCH:   rd_data = mscratch_q;
      CSR_MEPC:       rd_data = mepc_q;
      CSR_MCAUSE:     rd_data = mcause_q;
      CSR_MTVAL:      rd_data = mtval_q;
      CSR_MIP:        rd_data = 32'd0;
      CSR_MCYCLE:     rd_data = mcycle[31:0];
      CSR_MCYCLEH:    rd_data = mcycle[63:32];
      CSR_MINSTRET:   rd_data = minstret[31:0];
      CSR_MINSTRETH:  rd_data = minstret[63:32];
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MCONFIGPTR:
                      rd_data = 32'd0;
      CSR_MHARTID:    rd_data = MHARTID;
      default:        rd_impl = 1'b0;
    endcase
    // WB->ID bypass of a committing write; dropped writes never bypass
    if (w_wr && csr_is_writable(wb.csr_addr) && (wb.csr_addr == id_csr_addr_i))
      rd_data = w_wval;
  end

  assign id_csr_rdata_o   = rd_data;
  assign id_csr_illegal_o = !rd_impl || (id_csr_we_i && (id_csr_addr_i[11:10] == 2'b11));
  assign trap_vector_o    = {mtvec_q[31:2], 2'b00};
  assign mepc_o           = mepc_q;

endmodule
`default_nettype wire

// File: tb/tb_dtcore32_csr_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_dtcore32_csr_file
// Purpose  : Self-checking bench for dtcore32_csr_file: reset read table,
//            then directed sequences for bypass, trap, MRET, mtvec, counter
//            carry, minstret write priority, read-only writes, async reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dtcore32_csr_file;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] id_csr_addr_i = 12'd0;
  logic        id_csr_we_i = 1'b0;
  logic [31:0] id_csr_rdata_o;
  logic        id_csr_illegal_o;
  logic        wb_valid_i = 1'b0;
  logic        wb_csr_we_i = 1'b0;
  logic [11:0] wb_csr_addr_i = 12'd0;
  logic [31:0] wb_csr_wdata_i = 32'd0;
  logic        wb_trap_valid_i = 1'b0;
  logic [31:0] wb_trap_mcause_i = 32'd0;
  logic [31:0] wb_trap_pc_i = 32'd0;
  logic [31:0] wb_trap_mtval_i = 32'd0;
  logic        wb_mret_i = 1'b0;
  logic [31:0] trap_vector_o;
  logic [31:0] mepc_o;

  dtcore32_csr_file #(.MHARTID(32'd0), .MISA_VALUE(32'h4000_0100)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .id_csr_addr_i    (id_csr_addr_i),
    .id_csr_we_i      (id_csr_we_i),
    .id_csr_rdata_o   (id_csr_rdata_o),
    .id_csr_illegal_o (id_csr_illegal_o),
    .wb_valid_i       (wb_valid_i),
    .wb_csr_we_i      (wb_csr_we_i),
    .wb_csr_addr_i    (wb_csr_addr_i),
    .wb_csr_wdata_i   (wb_csr_wdata_i),
    .wb_trap_valid_i  (wb_trap_valid_i),
    .wb_trap_mcause_i (wb_trap_mcause_i),
    .wb_trap_pc_i     (wb_trap_pc_i),
    .wb_trap_mtval_i  (wb_trap_mtval_i),
    .wb_mret_i        (wb_mret_i),
    .trap_vector_o    (trap_vector_o),
    .mepc_o           (mepc_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       name;
    logic [11:0] addr;
    logic        we;
    logic [31:0] exp_data;
    logic        exp_ill;
  } rd_vec_t;

  rd_vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Combinational read; settles within 1 time unit
  task automatic rd(input logic [11:0] addr, input string name, input logic [31:0] exp);
    id_csr_addr_i = addr;
    id_csr_we_i   = 1'b0;
    #1;
    check(name, id_csr_rdata_o, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_idle();
    wb_valid_i = 1'b0; wb_csr_we_i = 1'b0; wb_csr_addr_i = 12'd0; wb_csr_wdata_i = 32'd0;
    wb_trap_valid_i = 1'b0; wb_trap_mcause_i = 32'd0; wb_trap_pc_i = 32'd0;
    wb_trap_mtval_i = 32'd0; wb_mret_i = 1'b0;
  endtask

  task automatic wb_write(input logic [11:0] addr, input logic [31:0] data);
    wb_idle();
    wb_valid_i = 1'b1; wb_csr_we_i = 1'b1; wb_csr_addr_i = addr; wb_csr_wdata_i = data;
  endtask

  initial begin
    vecs[0] = '{"rst_mstatus",    12'h300, 1'b0, 32'h0000_1800, 1'b0};
    vecs[1] = '{"rst_misa",       12'h301, 1'b0, 32'h4000_0100, 1'b0};
    vecs[2] = '{"unimpl_7c0",     12'h7C0, 1'b0, 32'h0000_0000, 1'b1};
    vecs[3] = '{"rst_mhartid",    12'hF14, 1'b0, 32'h0000_0000, 1'b0};
    vecs[4] = '{"rst_mtvec",      12'h305, 1'b0, 32'h0000_0000, 1'b0};
    vecs[5] = '{"rst_mepc",       12'h341, 1'b0, 32'h0000_0000, 1'b0};
    vecs[6] = '{"mvendorid_we",   12'hF11, 1'b1, 32'h0000_0000, 1'b1};
    vecs[7] = '{"mvendorid_rd",   12'hF11, 1'b0, 32'h0000_0000, 1'b0};
    vecs[8] = '{"misa_we_legal",  12'h301, 1'b1, 32'h4000_0100, 1'b0};
    vecs[9] = '{"mip_rd",         12'h344, 1'b0, 32'h0000_0000, 1'b0};

    wb_idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    check("rst_trap_vector", trap_vector_o, 32'h0);
    check("rst_mepc_o", mepc_o, 32'h0);
    for (int i = 0; i < 10; i++) begin
      id_csr_addr_i = vecs[i].addr;
      id_csr_we_i   = vecs[i].we;
      #1;
      check({vecs[i].name, "_data"}, id_csr_rdata_o, vecs[i].exp_data);
      check({vecs[i].name, "_ill"}, {31'd0, id_csr_illegal_o}, {31'd0, vecs[i].exp_ill});
    end
    id_csr_we_i = 1'b0;
    cycle();

    // mstatus write of all ones: only MIE/MPIE stick, MPP hardwired
    wb_write(12'h300, 32'hFFFF_FFFF);
    rd(12'h300, "mstatus_bypass", 32'h0000_1888);
    cycle();
    wb_idle();
    rd(12'h300, "mstatus_written", 32'h0000_1888);

    // Trap with a simultaneous mscratch write that must be dropped
    wb_write(12'h340, 32'h1234_5678);
    wb_trap_valid_i  = 1'b1;
    wb_trap_mcause_i = 32'd2;
    wb_trap_pc_i     = 32'h0000_0106;
    wb_trap_mtval_i  = 32'hDEAD_BEEF;
    rd(12'h340, "trap_no_bypass", 32'h0);
    cycle();
    wb_idle();
    check("trap_mepc_o", mepc_o, 32'h0000_0104);
    rd(12'h341, "trap_mepc", 32'h0000_0104);
    rd(12'h342, "trap_mcause", 32'h2);
    rd(12'h343, "trap_mtval", 32'hDEAD_BEEF);
    rd(12'h300, "trap_mstatus", 32'h0000_1880);
    rd(12'h340, "trap_mscratch", 32'h0);
    cycle();

    // MRET together with an mstatus write of 0: MRET wins
    wb_write(12'h300, 32'h0);
    wb_mret_i = 1'b1;
    cycle();
    wb_idle();
    rd(12'h300, "mret_mstatus", 32'h0000_1888);

    // mtvec low bits forced to zero
    wb_write(12'h305, 32'h8000_0103);
    cycle();
    wb_idle();
    check("trap_vector", trap_vector_o, 32'h8000_0100);
    rd(12'h305, "mtvec_rd", 32'h8000_0100);

    // mcycle carry into mcycleh
    wb_write(12'hB00, 32'hFFFF_FFFF);
    cycle();
    wb_write(12'hB80, 32'h0);
    rd(12'hB00, "mcycle_no_inc_bypass", 32'hFFFF_FFFF);
    rd(12'hB80, "mcycleh_bypass", 32'h0);
    cycle();
    wb_idle();
    cycle();
    rd(12'hB00, "mcycle_wrap_lo", 32'h0);
    rd(12'hB80, "mcycle_wrap_hi", 32'h1);

    // minstret write on a retiring instruction: no +1
    wb_write(12'hB02, 32'h55);
    cycle();
    wb_idle();
    rd(12'hB02, "minstret_written", 32'h55);
    cycle();
    rd(12'hB02, "minstret_idle_hold", 32'h55);
    wb_valid_i = 1'b1;
    cycle();
    wb_idle();
    rd(12'hB02, "minstret_retire", 32'h56);
    wb_write(12'hB02, 32'hFFFF_FFFF);
    cycle();
    wb_idle();
    wb_valid_i = 1'b1;
    cycle();
    wb_idle();
    rd(12'hB02, "minstret_wrap_lo", 32'h0);
    rd(12'hB82, "minstret_wrap_hi", 32'h1);

    // Read-only write dropped; misa ignores writes
    wb_write(12'hF11, 32'hABCD_1234);
    rd(12'hF11, "mvendorid_no_bypass", 32'h0);
    cycle();
    wb_write(12'h301, 32'h0);
    cycle();
    wb_idle();
    rd(12'hF11, "mvendorid_after_wr", 32'h0);
    rd(12'h301, "misa_after_wr", 32'h4000_0100);

    // Asynchronous reset mid-operation
    wb_write(12'h340, 32'h77);
    cycle();
    wb_idle();
    rd(12'h340, "mscratch_set", 32'h77);
    #2 rst_n = 1'b0;
    #1;
    check("arst_mepc_o", mepc_o, 32'h0);
    check("arst_trap_vector", trap_vector_o, 32'h0);
    rd(12'h300, "arst_mstatus", 32'h0000_1800);
    rd(12'h340, "arst_mscratch", 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
